teclado_matricial_param: RTL and testbench
==========================================

# teclado_matricial_param

Parametrised matrix-keypad scanner and digit collector, the next generation of the lock's keypad decoder. It drives one-hot active-low rows and samples active-low columns. It debounces presses, maps them to lock key codes and accumulates up to MAX_DIG digits. It emits the collected sequence on '#', plus per-key bip and inactivity-timeout pulses for the operational and setup FSMs.

## Interface
- N_LIN, 4: keypad rows, 1..8
- N_COL, 4: keypad columns, 1..8
- MAX_DIG, 20: digit buffer depth, 1..32
- SCAN_CYC, 1000: dwell cycles per row
- DEBOUNCE_CYC, 50000: cycles a key must stay stable for press and release
- TIMEOUT_CYC, 250000000: idle cycles before a partial entry is discarded
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  scanning/collection allowed
- col_matriz  in  N_COL  column sense, active-low
- lin_matriz  out  N_LIN  row drive, one-hot active-low
- digitos_value  out  4*MAX_DIG  packed BCD digits; nibble 0 = most recent; empty = 0xF
- digitos_valid  out  1  one-cycle pulse, digitos_value holds the submitted sequence
- tecla_bip  out  1  one-cycle pulse per accepted mapped key
- timeout  out  1  one-cycle pulse when a partial entry expires

## Operation
- Reset values:
  - lin_matriz: all 1s
  - digitos_value: all 0xF
  - digitos_valid, tecla_bip, timeout: 0
  - row index 0, buffer empty, FSM SCAN
- Key index = row*N_COL + col.
  - The package KEYMAP (16 entries) covers indices 0..15 and maps them as follows:
    - row 0: 1 2 3 A
    - row 1: 4 5 6 B
    - row 2: 7 8 9 C
    - row 3: * 0 # D
  - Indices ≥16 and A–D are ignored: no bip, no buffer change.
- FSM, SCAN → DEBOUNCE → HOLD:
  - SCAN: drive the current row low for SCAN_CYC cycles and sample the columns on the last dwell cycle.
    - Exactly one column low: latch (row, col) and go to DEBOUNCE.
    - Otherwise advance the row, wrapping N_LIN-1 → 0.
  - DEBOUNCE: the row stays driven.
    - If the same single column stays low for DEBOUNCE_CYC consecutive cycles, accept the key and go to HOLD.
    - Any change returns to SCAN on the next row.
  - HOLD: wait until all columns are high for DEBOUNCE_CYC consecutive cycles, then go to SCAN on the next row.
  - A key held down is accepted exactly once.
- Accepted key actions:
  - Digit: shift the buffer up one nibble and insert at nibble 0. When the buffer is full, the oldest digit is dropped.
  - '*': clear the buffer to all 0xF.
  - '#' with a non-empty buffer: present the buffer on digitos_value with digitos_valid for one cycle, then clear the buffer.
  - '#' with an empty buffer: bip only, no digitos_valid.
- Between submissions, digitos_value holds the last submitted sequence. It is not a live view of the buffer.
- Timeout counter:
  - Runs only while the buffer is non-empty.
  - Cleared on every accepted key.
  - On reaching TIMEOUT_CYC: clear the buffer and pulse timeout.
- enable low: all rows high, FSM forced to SCAN at row 0, buffer and timeout counter cleared, no pulses. digitos_value retains its value.
- Priority, highest first: rst, enable low, timeout, key acceptance.
  - A timeout and a key acceptance in the same cycle: only the timeout takes effect.

## Timing
- Key accept occurs on the cycle the DEBOUNCE counter reaches DEBOUNCE_CYC. tecla_bip is registered and is high on the following cycle.
- For '#', digitos_valid and the updated digitos_value appear in the same cycle as tecla_bip.
- Worst-case detect latency from a stable press: N_LIN*SCAN_CYC + DEBOUNCE_CYC + 1 cycles.
- The earliest next key is accepted no sooner than 2*DEBOUNCE_CYC + SCAN_CYC cycles after the previous one.
- Counter widths are $clog2 of the respective parameter + 1. No counter wraps; each saturates at its terminal value until cleared.
- col_matriz passes through a 2-flop synchroniser. Its 2-cycle delay is included in the dwell sampling, so the sample is taken on the last dwell cycle.

## Structure
- Shared package teclado_pkg holds:
  - key code enum: DIG0..DIG9, K_STAR, K_HASH, K_NONE
  - KEYMAP constant
  - EMPTY_NIBBLE = 4'hF
  - FSM state enum
- One sub-module, teclado_scan: row drive, synchroniser, SCAN/DEBOUNCE/HOLD FSM. It outputs key_code plus a key_acc one-cycle strobe.
- The top contains the digit buffer, '#'/'*' handling, timeout counter and output registers.

## Test plan
All scenarios use N_LIN=4, N_COL=4, SCAN_CYC=4, DEBOUNCE_CYC=8, MAX_DIG=4, TIMEOUT_CYC=200.
- Press 1,2,3,# with releases → one digitos_valid with digitos_value=16'hF123, four tecla_bip pulses; the buffer is then empty.
- Press 1..6 then # → digitos_value=16'h3456 (oldest digits dropped); '#' with an empty buffer → bip, no digitos_valid.
- Press 5 with 3-cycle bounce glitches, then hold 100 cycles → exactly one bip; a glitch shorter than 8 cycles → no bip.
- Press 7, then idle 200 cycles → timeout pulse, no digitos_valid; a subsequent # yields no digitos_valid.
- Press 9,*,4,# → digitos_value=16'hFFF4; pressing A or two keys in one row simultaneously → no bip, no change.
- Press 8, deassert enable mid-DEBOUNCE of the next key, then reassert → lin_matriz=4'hF while disabled; the buffer was cleared, so # yields no digitos_valid; rst mid-HOLD returns all outputs to reset values the next cycle.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared definitions for the matrix keypad scanner: key codes, the
// keypad layout table, the empty-digit marker and the scanner states.
package teclado_pkg;

   typedef enum logic [3:0] {
      DIG0   = 4'd0,
      DIG1   = 4'd1,
      DIG2   = 4'd2,
      DIG3   = 4'd3,
      DIG4   = 4'd4,
      DIG5   = 4'd5,
      DIG6   = 4'd6,
      DIG7   = 4'd7,
      DIG8   = 4'd8,
      DIG9   = 4'd9,
      K_STAR = 4'hA,
      K_HASH = 4'hB,
      K_NONE = 4'hF
   } key_code_t;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HOLD
   } scan_state_t;

   localparam logic [3:0] EMPTY_NIBBLE = 4'hF;

   // Physical layout, index = row*4 + col. The letter keys carry no
   // meaning for the lock and map to K_NONE.
   localparam key_code_t KEYMAP [16] = '{
      DIG1,   DIG2, DIG3,   K_NONE,
      DIG4,   DIG5, DIG6,   K_NONE,
      DIG7,   DIG8, DIG9,   K_NONE,
      K_STAR, DIG0, K_HASH, K_NONE
   };

   // Keys outside the 4x4 table exist on larger keypads but are ignored.
   function automatic key_code_t map_key(input logic [6:0] idx);
      return (idx < 7'd16) ? KEYMAP[idx[3:0]] : K_NONE;
   endfunction

endpackage

// File: rtl/teclado_scan.sv
// Row driver, column synchroniser and SCAN/DEBOUNCE/HOLD state machine.
// Emits the code of the debounced key together with a one-cycle key_acc
// strobe; a key held down produces exactly one strobe.
module teclado_scan
   import teclado_pkg::*;
#(
   parameter int N_LIN        = 4,
   parameter int N_COL        = 4,
   parameter int SCAN_CYC     = 1000,
   parameter int DEBOUNCE_CYC = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [N_COL-1:0] col_matriz,
   output logic [N_LIN-1:0] lin_matriz,
   output key_code_t        key_code,
   output logic             key_acc
);

   localparam int LIN_W  = (N_LIN > 1) ? $clog2(N_LIN) : 1;
   localparam int COL_W  = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam int SCAN_W = $clog2(SCAN_CYC) + 1;
   localparam int DEB_W  = $clog2(DEBOUNCE_CYC) + 1;

   scan_state_t      state, state_nxt;
   logic [LIN_W-1:0] lin_idx, lin_idx_nxt, lin_inc;
   logic [N_COL-1:0] col_s1, col_s2, col_lat, col_lat_nxt;
   logic [SCAN_W-1:0] scan_cnt, scan_cnt_nxt;
   logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
   logic [COL_W-1:0] col_sel;
   key_code_t        key_code_nxt;

   // Two-flop synchroniser for the asynchronous column inputs.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the chain.
      if (rst) begin
         col_s1 <= '1;
         col_s2 <= '1;
      end else begin
         col_s1 <= col_matriz;
         col_s2 <= col_s1;
      end
   end

   // Encode the lowest active (low) column of the synchronised sample.
   always_comb begin
      col_sel = '0;
      for (int c = N_COL - 1; c >= 0; c--) begin
         if (!col_s2[c]) col_sel = COL_W'(c);
      end
   end

   assign lin_inc = (lin_idx == LIN_W'(N_LIN - 1)) ? '0 : lin_idx + LIN_W'(1);

   // Next-state logic: dwell per row, debounce a single low column, then
   // wait for a stable release before resuming the scan on the next row.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_nxt    = state;
      lin_idx_nxt  = lin_idx;
      col_lat_nxt  = col_lat;
      scan_cnt_nxt = scan_cnt;
      deb_cnt_nxt  = deb_cnt;
      key_code_nxt = key_code;
      key_acc      = 1'b0;
      case (state)
         SCAN: begin
            if (scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
               scan_cnt_nxt = '0;
               if ($onehot(~col_s2)) begin
                  state_nxt    = DEBOUNCE;
                  col_lat_nxt  = col_s2;
                  deb_cnt_nxt  = '0;
                  key_code_nxt = map_key(7'(lin_idx) * 7'(N_COL) + 7'(col_sel));
               end else begin
                  lin_idx_nxt = lin_inc;
               end
            end else begin
               scan_cnt_nxt = scan_cnt + SCAN_W'(1);
            end
         end
         DEBOUNCE: begin
            if (deb_cnt == DEB_W'(DEBOUNCE_CYC)) begin
               key_acc     = 1'b1;
               state_nxt   = HOLD;
               deb_cnt_nxt = '0;
            end else if (col_s2 != col_lat) begin
               state_nxt   = SCAN;
               lin_idx_nxt = lin_inc;
               deb_cnt_nxt = '0;
            end else begin
               deb_cnt_nxt = deb_cnt + DEB_W'(1);
            end
         end
         HOLD: begin
            if (deb_cnt == DEB_W'(DEBOUNCE_CYC)) begin
               state_nxt   = SCAN;
               lin_idx_nxt = lin_inc;
               deb_cnt_nxt = '0;
            end else if (col_s2 == '1) begin
               deb_cnt_nxt = deb_cnt + DEB_W'(1);
            end else begin
               deb_cnt_nxt = '0;
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   // State register; disabling parks the scanner on row 0 with rows idle.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state      <= SCAN;
         lin_idx    <= '0;
         col_lat    <= '1;
         scan_cnt   <= '0;
         deb_cnt    <= '0;
         key_code   <= K_NONE;
         lin_matriz <= '1;
      end else begin
         state      <= state_nxt;
         lin_idx    <= lin_idx_nxt;
         col_lat    <= col_lat_nxt;
         scan_cnt   <= scan_cnt_nxt;
         deb_cnt    <= deb_cnt_nxt;
         key_code   <= key_code_nxt;
         lin_matriz <= ~(N_LIN'(1) << lin_idx_nxt);
      end
   end

endmodule

// File: rtl/teclado_matricial_param.sv
// Keypad digit collector: buffers digits from the scanner, clears on '*',
// submits the sequence on '#', and discards a stale partial entry.
module teclado_matricial_param
   import teclado_pkg::*;
#(
   parameter int N_LIN        = 4,
   parameter int N_COL        = 4,
   parameter int MAX_DIG      = 20,
   parameter int SCAN_CYC     = 1000,
   parameter int DEBOUNCE_CYC = 50000,
   parameter int TIMEOUT_CYC  = 250000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N_COL-1:0]     col_matriz,
   output logic [N_LIN-1:0]     lin_matriz,
   output logic [4*MAX_DIG-1:0] digitos_value,
   output logic                 digitos_valid,
   output logic                 tecla_bip,
   output logic                 timeout
);

   localparam int BUF_W = 4 * MAX_DIG;
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   key_code_t        key_code;
   logic             key_acc;
   logic [BUF_W-1:0] digit_buf, digit_buf_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
   logic             buf_nonempty, timeout_hit, key_ok;
   logic             value_load, bip_nxt;

   teclado_scan #(
      .N_LIN        (N_LIN),
      .N_COL        (N_COL),
      .SCAN_CYC     (SCAN_CYC),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_scan (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .col_matriz (col_matriz),
      .lin_matriz (lin_matriz),
      .key_code   (key_code),
      .key_acc    (key_acc)
   );

   // Digits are always 0..9, so an empty marker in nibble 0 means no digits.
   assign buf_nonempty = (digit_buf[3:0] != EMPTY_NIBBLE);
   assign timeout_hit  = buf_nonempty && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
   assign key_ok       = key_acc && (key_code != K_NONE);

   // Buffer and timeout update; an expiring entry overrides a key accept.
   always_comb begin
      digit_buf_nxt = digit_buf;
      tmo_cnt_nxt   = tmo_cnt;
      value_load    = 1'b0;
      bip_nxt       = 1'b0;
      if (timeout_hit) begin
         digit_buf_nxt = '1;
         tmo_cnt_nxt   = '0;
      end else if (key_ok) begin
         bip_nxt     = 1'b1;
         tmo_cnt_nxt = '0;
         case (key_code)
            K_STAR: digit_buf_nxt = '1;
            K_HASH: begin
               if (buf_nonempty) begin
                  value_load    = 1'b1;
                  digit_buf_nxt = '1;
               end
            end
            default: begin
               digit_buf_nxt      = digit_buf << 4;
               digit_buf_nxt[3:0] = key_code;
            end
         endcase
      end else if (buf_nonempty) begin
         tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt_nxt = '0;
      end
   end

   // Output and buffer registers; digitos_value only changes on submission.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the digit buffer must be reset, not left to power-up
         // contents, because all-F is what marks it empty.
         digit_buf     <= '1;
         tmo_cnt       <= '0;
         digitos_value <= '1;
         digitos_valid <= 1'b0;
         tecla_bip     <= 1'b0;
         timeout       <= 1'b0;
      end else if (!enable) begin
         digit_buf     <= '1;
         tmo_cnt       <= '0;
         digitos_valid <= 1'b0;
         tecla_bip     <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         digit_buf     <= digit_buf_nxt;
         tmo_cnt       <= tmo_cnt_nxt;
         digitos_valid <= value_load;
         tecla_bip     <= bip_nxt;
         timeout       <= timeout_hit;
         if (value_load) digitos_value <= digit_buf;
      end
   end

endmodule

// File: tb/tb_teclado_matricial_param.sv
// Directed bench for the keypad collector with a small 4x4 keypad model.
module tb_teclado_matricial_param;
   import teclado_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [3:0]  col_matriz;
   logic [3:0]  lin_matriz;
   logic [15:0] digitos_value;
   logic        digitos_valid;
   logic        tecla_bip;
   logic        timeout;

   logic [15:0] keys = '0;
   int n_vec = 0;
   int n_err = 0;
   int n_bip = 0;
   int n_valid = 0;
   int n_tmo = 0;

   typedef struct packed {
      logic [63:0] seq;
      logic [7:0]  exp_bip;
      logic [7:0]  exp_valid;
      logic [15:0] exp_value;
   } vec_t;

   vec_t vecs [7];

   teclado_matricial_param #(
      .N_LIN(4), .N_COL(4), .MAX_DIG(4),
      .SCAN_CYC(4), .DEBOUNCE_CYC(8), .TIMEOUT_CYC(200)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .col_matriz    (col_matriz),
      .lin_matriz    (lin_matriz),
      .digitos_value (digitos_value),
      .digitos_valid (digitos_valid),
      .tecla_bip     (tecla_bip),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_matriz = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!lin_matriz[r] && keys[r*4+c]) col_matriz[c] = 1'b0;
   end

   // Pulse counters sampled on the falling edge.
   always @(negedge clk) begin
      if (tecla_bip)     n_bip   <= n_bip + 1;
      if (digitos_valid) n_valid <= n_valid + 1;
      if (timeout)       n_tmo   <= n_tmo + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int key_of(input logic [7:0] ch);
      case (ch)
         "1": return 0;   "2": return 1;   "3": return 2;   "A": return 3;
         "4": return 4;   "5": return 5;   "6": return 6;   "B": return 7;
         "7": return 8;   "8": return 9;   "9": return 10;  "C": return 11;
         "*": return 12;  "0": return 13;  "#": return 14;  default: return 15;
      endcase
   endfunction

   task automatic press(input int idx, input int hold_cyc);
      keys = 16'(1) << idx;
      repeat (hold_cyc) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
   endtask

   task automatic wait_state(input scan_state_t s, input string name);
      int k;
      k = 0;
      while (u_dut.u_scan.state != s && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(k < 100), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_lin"},   32'(lin_matriz),    32'hF);
      check({tag, "_value"}, 32'(digitos_value), 32'hFFFF);
      check({tag, "_valid"}, 32'(digitos_valid), 32'd0);
      check({tag, "_bip"},   32'(tecla_bip),     32'd0);
      check({tag, "_tmo"},   32'(timeout),       32'd0);
   endtask

   initial begin
      int b0, v0, t0;
      logic [7:0] ch;

      vecs[0] = '{seq: 64'("123#"),    exp_bip: 8'd4, exp_valid: 8'd1, exp_value: 16'hF123};
      vecs[1] = '{seq: 64'("123456#"), exp_bip: 8'd7, exp_valid: 8'd1, exp_value: 16'h3456};
      vecs[2] = '{seq: 64'("#"),       exp_bip: 8'd1, exp_valid: 8'd0, exp_value: 16'h3456};
      vecs[3] = '{seq: 64'("9*4#"),    exp_bip: 8'd4, exp_valid: 8'd1, exp_value: 16'hFFF4};
      vecs[4] = '{seq: 64'("A#"),      exp_bip: 8'd1, exp_valid: 8'd0, exp_value: 16'hFFF4};
      vecs[5] = '{seq: 64'("D07#"),    exp_bip: 8'd3, exp_valid: 8'd1, exp_value: 16'hFF07};
      vecs[6] = '{seq: 64'("BC89#"),   exp_bip: 8'd3, exp_valid: 8'd1, exp_value: 16'hFF89};

      rst = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         b0 = n_bip;
         v0 = n_valid;
         for (int b = 7; b >= 0; b--) begin
            ch = vecs[i].seq[b*8 +: 8];
            if (ch != 8'd0) press(key_of(ch), 60);
         end
         check($sformatf("vec%0d_bip", i),   32'(n_bip - b0),    32'(vecs[i].exp_bip));
         check($sformatf("vec%0d_valid", i), 32'(n_valid - v0),  32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_value", i), 32'(digitos_value), 32'(vecs[i].exp_value));
      end
      check("no_timeout_yet", 32'(n_tmo), 32'd0);

      // Bouncing '5' then a steady hold, then a short glitch.
      b0 = n_bip;
      v0 = n_valid;
      for (int g = 0; g < 4; g++) begin
         keys = 16'(1) << 5;
         repeat (3) @(negedge clk);
         keys = '0;
         repeat (3) @(negedge clk);
      end
      press(5, 100);
      check("bounce_bip", 32'(n_bip - b0), 32'd1);
      keys = 16'(1) << 5;
      repeat (5) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      check("glitch_bip", 32'(n_bip - b0), 32'd1);
      press(key_of("#"), 60);
      check("bounce_valid", 32'(n_valid - v0), 32'd1);
      check("bounce_value", 32'(digitos_value), 32'hFFF5);

      // Two keys in one row are ignored; then 6 and '#'.
      b0 = n_bip;
      keys = 16'h0003;
      repeat (60) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      check("twokey_bip", 32'(n_bip - b0), 32'd0);
      press(key_of("6"), 60);
      press(key_of("#"), 60);
      check("twokey_value", 32'(digitos_value), 32'hFFF6);

      // Partial entry expires.
      t0 = n_tmo;
      v0 = n_valid;
      press(key_of("7"), 60);
      repeat (250) @(negedge clk);
      check("tmo_pulse", 32'(n_tmo - t0), 32'd1);
      check("tmo_no_valid", 32'(n_valid - v0), 32'd0);
      b0 = n_bip;
      press(key_of("#"), 60);
      check("tmo_hash_valid", 32'(n_valid - v0), 32'd0);
      check("tmo_hash_bip", 32'(n_bip - b0), 32'd1);

      // Disable in the middle of debouncing the second key.
      press(key_of("8"), 60);
      keys = 16'(1) << key_of("9");
      wait_state(DEBOUNCE, "en_reach_debounce");
      repeat (3) @(negedge clk);
      enable = 1'b0;
      b0 = n_bip;
      repeat (2) @(negedge clk);
      check("en_lin_idle", 32'(lin_matriz), 32'hF);
      repeat (20) @(negedge clk);
      check("en_no_bip", 32'(n_bip - b0), 32'd0);
      keys = '0;
      repeat (5) @(negedge clk);
      enable = 1'b1;
      repeat (10) @(negedge clk);
      v0 = n_valid;
      b0 = n_bip;
      press(key_of("#"), 60);
      check("en_hash_valid", 32'(n_valid - v0), 32'd0);
      check("en_hash_bip", 32'(n_bip - b0), 32'd1);
      check("en_value_kept", 32'(digitos_value), 32'hFFF6);

      // Synchronous reset while a key is held.
      keys = 16'(1) << key_of("2");
      wait_state(HOLD, "rst_reach_hold");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      keys = '0;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
